// File: rtl/mu0_demux16.sv
// -----------------------------------------------------------------------------
// mu0_demux16
// Registered 1-to-2 demultiplexer for the MU0 datapath. One word from the
// shared source bus is steered into one of two destination channels. Each
// channel has a one-entry holding register with a valid/ready handshake, so a
// stalled destination never blocks or corrupts the other channel.
//
// Optional feature macro: MU0_DEMUX_CNT_EN
//   When defined, adds per-channel 8-bit drain counters (cnt0, cnt1) that
//   increment on every drain of their channel and wrap from 8'hFF to 8'h00.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset, synchronous release
//   in_data    in   [WIDTH] source word
//   in_sel     in   destination select (0 -> channel 0, 1 -> channel 1)
//   in_valid   in   source presents a word
//   in_ready   out  block accepts the word this cycle (combinational)
//   out0_data  out  [WIDTH] channel 0 held word
//   out0_valid out  channel 0 holds a word
//   out0_ready in   channel 0 consumer takes the word
//   out1_data  out  [WIDTH] channel 1 held word
//   out1_valid out  channel 1 holds a word
//   out1_ready in   channel 1 consumer takes the word
//   cnt0/cnt1  out  [8] drain counters (MU0_DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
module mu0_demux16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef MU0_DEMUX_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_r     [2];
  chan_state_e      state_nxt_s [2];
  logic [WIDTH-1:0] data_r      [2];
  logic [1:0]       valid_s;
  logic [1:0]       load_s;
  logic [1:0]       drain_s;
  logic             accept_s;

  // Occupancy comes straight from the state registers.
  assign valid_s[0] = (state_r[0] == FULL);
  assign valid_s[1] = (state_r[1] == FULL);

  // A channel can take a word when it is empty or is being drained this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (in_sel) begin
      in_ready = ~valid_s[1] | out1_ready;
    end else begin
      in_ready = ~valid_s[0] | out0_ready;
    end
  end

  assign accept_s   = in_valid & in_ready;
  assign load_s[0]  = accept_s & ~in_sel;
  assign load_s[1]  = accept_s & in_sel;
  assign drain_s[0] = valid_s[0] & out0_ready;
  assign drain_s[1] = valid_s[1] & out1_ready;

  // Per-channel next-state: a load always leaves the channel FULL, which
  // covers the simultaneous drain-and-load (zero-bubble) case.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        EMPTY: begin
          if (load_s[i]) begin
            state_nxt_s[i] = FULL;
          end else begin
            state_nxt_s[i] = EMPTY;
          end
        end
        FULL: begin
          if (drain_s[i] && !load_s[i]) begin
            state_nxt_s[i] = EMPTY;
          end else begin
            state_nxt_s[i] = FULL;
          end
        end
        default: begin
          state_nxt_s[i] = EMPTY;
        end
      endcase
    end
  end

  // Channel state registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r[0] <= EMPTY;
      state_r[1] <= EMPTY;
    end else begin
      state_r[0] <= state_nxt_s[0];
      state_r[1] <= state_nxt_s[1];
    end
  end

  // Holding registers only change on a load, so data is stable while stalled
  // and keeps its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r[0] <= {WIDTH{1'b0}};
      data_r[1] <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load_s[i]) begin
          data_r[i] <= in_data;
        end else begin
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  assign out0_data  = data_r[0];
  assign out1_data  = data_r[1];
  assign out0_valid = valid_s[0];
  assign out1_valid = valid_s[1];

`ifdef MU0_DEMUX_CNT_EN
  logic [7:0] cnt_r [2];

  // Drain counters; natural 8-bit overflow gives the FF -> 00 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r[0] <= 8'h00;
      cnt_r[1] <= 8'h00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (drain_s[i]) begin
          cnt_r[i] <= cnt_r[i] + 8'h01;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign cnt0 = cnt_r[0];
  assign cnt1 = cnt_r[1];
`endif

endmodule
